// File: rtl/arbitro_memoria_jogo_if.sv
// Bus between the board-memory arbiter, its four requesters and the two board RAMs.
// slave is the arbiter side; master is the requesters plus memory side.
interface arbitro_memoria_jogo_if #(
    parameter int DATA_W = 64
);
    logic              req_val, req_col, req_pts, req_vga;
    logic              jog_val, jog_col, jog_pts, jog_vga;
    logic [4:0]        addr_val, addr_col, addr_pts, addr_vga;
    logic              we_val, we_col;
    logic [DATA_W-1:0] wdata_val, wdata_col;

    logic              gnt_val, gnt_col, gnt_pts, gnt_vga;
    logic              rvalid_val, rvalid_col, rvalid_pts, rvalid_vga;
    logic [DATA_W-1:0] rdata;

    logic [4:0]        mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wrenP1, mem_wrenP2;
    logic [DATA_W-1:0] mem_q_p1, mem_q_p2;

    logic              busy;
    logic [1:0]        owner;

    modport slave (
        input  req_val, req_col, req_pts, req_vga,
        input  jog_val, jog_col, jog_pts, jog_vga,
        input  addr_val, addr_col, addr_pts, addr_vga,
        input  we_val, we_col, wdata_val, wdata_col,
        input  mem_q_p1, mem_q_p2,
        output gnt_val, gnt_col, gnt_pts, gnt_vga,
        output rvalid_val, rvalid_col, rvalid_pts, rvalid_vga, rdata,
        output mem_addr, mem_data, mem_wrenP1, mem_wrenP2,
        output busy, owner
    );

    modport master (
        output req_val, req_col, req_pts, req_vga,
        output jog_val, jog_col, jog_pts, jog_vga,
        output addr_val, addr_col, addr_pts, addr_vga,
        output we_val, we_col, wdata_val, wdata_col,
        output mem_q_p1, mem_q_p2,
        input  gnt_val, gnt_col, gnt_pts, gnt_vga,
        input  rvalid_val, rvalid_col, rvalid_pts, rvalid_vga, rdata,
        input  mem_addr, mem_data, mem_wrenP1, mem_wrenP2,
        input  busy, owner
    );
endinterface

// File: rtl/arbitro_memoria_jogo.sv
// Four-way arbiter for the two game-board RAMs (player 1 / player 2): fixed priority
// val > col > pts > vga, VGA aging promotion, per-grant hold limit, 1-cycle read return.
module arbitro_memoria_jogo #(
    parameter int HOLD_MAX    = 32,
    parameter int AGING_LIMIT = 8,
    parameter int DATA_W      = 64
) (
    input logic                   clk,
    input logic                   resetGeral,
    arbitro_memoria_jogo_if.slave bus
);
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    localparam int AGE_W  = $clog2(AGING_LIMIT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [AGE_W-1:0]  AGE_TOP   = AGE_W'(AGING_LIMIT);

    localparam logic [1:0] OWN_VAL = 2'd0;
    localparam logic [1:0] OWN_COL = 2'd1;
    localparam logic [1:0] OWN_PTS = 2'd2;
    localparam logic [1:0] OWN_VGA = 2'd3;

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t            state, state_nx;
    logic [1:0]        owner_q;
    logic [1:0]        winner;
    logic              any_req;
    logic              aged;
    logic              vga_granted;
    logic [HOLD_W-1:0] hold_cnt;
    logic [AGE_W-1:0]  age_cnt;

    logic              own_req;
    logic              own_jog;
    logic              own_we;
    logic [4:0]        own_addr;
    logic [DATA_W-1:0] own_wdata;

    logic              access;
    logic              wr_access;
    logic              rd_access;
    logic              last_access;

    logic              rd_vld_p1;
    logic [1:0]        rd_own_p1;
    logic              rd_jog_p1;

    // Current owner's request lines, selected from the registered owner
    always_comb begin
        own_req   = 1'b0;
        own_jog   = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        unique case (owner_q)
            OWN_VAL: begin
                own_req   = bus.req_val;
                own_jog   = bus.jog_val;
                own_we    = bus.we_val;
                own_addr  = bus.addr_val;
                own_wdata = bus.wdata_val;
            end
            OWN_COL: begin
                own_req   = bus.req_col;
                own_jog   = bus.jog_col;
                own_we    = bus.we_col;
                own_addr  = bus.addr_col;
                own_wdata = bus.wdata_col;
            end
            OWN_PTS: begin
                own_req  = bus.req_pts;
                own_jog  = bus.jog_pts;
                own_addr = bus.addr_pts;
            end
            default: begin
                own_req  = bus.req_vga;
                own_jog  = bus.jog_vga;
                own_addr = bus.addr_vga;
            end
        endcase
    end

    assign access      = (state == GRANTED) && own_req;
    assign wr_access   = access && own_we;
    assign rd_access   = access && !own_we;
    assign last_access = access && (hold_cnt == HOLD_LAST);
    assign vga_granted = (state == GRANTED) && (owner_q == OWN_VGA);
    assign aged        = (age_cnt == AGE_TOP);
    assign any_req     = bus.req_val | bus.req_col | bus.req_pts | bus.req_vga;

    // An aged VGA request jumps ahead of the fixed priority order
    always_comb begin
        winner = OWN_VAL;
        if (aged && bus.req_vga)  winner = OWN_VGA;
        else if (bus.req_val)     winner = OWN_VAL;
        else if (bus.req_col)     winner = OWN_COL;
        else if (bus.req_pts)     winner = OWN_PTS;
        else                      winner = OWN_VGA;
    end

    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) state <= IDLE;
        else             state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = GRANTED;
            GRANTED: if (!own_req || last_access) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state == GRANTED);
        bus.owner      = owner_q;
        bus.gnt_val    = (state == GRANTED) && (owner_q == OWN_VAL);
        bus.gnt_col    = (state == GRANTED) && (owner_q == OWN_COL);
        bus.gnt_pts    = (state == GRANTED) && (owner_q == OWN_PTS);
        bus.gnt_vga    = vga_granted;
        bus.mem_addr   = access ? own_addr : 5'd0;
        bus.mem_data   = wr_access ? own_wdata : '0;
        bus.mem_wrenP1 = wr_access && !own_jog;
        bus.mem_wrenP2 = wr_access && own_jog;
    end

    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            owner_q  <= OWN_VAL;
            hold_cnt <= '0;
            age_cnt  <= '0;
        end else begin
            if (state == IDLE && any_req) owner_q <= winner;

            if (state == IDLE)  hold_cnt <= '0;
            else if (access)    hold_cnt <= hold_cnt + 1'b1;

            if (vga_granted)                 age_cnt <= '0;
            else if (bus.req_vga && !aged)   age_cnt <= age_cnt + 1'b1;
        end
    end

    // Read return stage: memory answers one cycle after the access
    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) rd_vld_p1 <= 1'b0;
        else             rd_vld_p1 <= rd_access;
    end

    always_ff @(posedge clk) begin
        rd_own_p1 <= owner_q;
        rd_jog_p1 <= own_jog;
    end

    always_comb begin
        bus.rvalid_val = rd_vld_p1 && (rd_own_p1 == OWN_VAL);
        bus.rvalid_col = rd_vld_p1 && (rd_own_p1 == OWN_COL);
        bus.rvalid_pts = rd_vld_p1 && (rd_own_p1 == OWN_PTS);
        bus.rvalid_vga = rd_vld_p1 && (rd_own_p1 == OWN_VGA);
        bus.rdata      = '0;
        if (rd_vld_p1) bus.rdata = rd_jog_p1 ? bus.mem_q_p2 : bus.mem_q_p1;
    end

endmodule
